regfile_read_stage: RTL and testbench

//  Read side of the 32x32-bit register file. Takes the flattened 1024-bit

---
 rtl/regfile_read_stage.sv | 133 +++++++++++++
 tb/tb_regfile_read_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_stage.sv
// Read side of the 32x32 register file feeding the ID/EX boundary.
// Selects two operands from the flattened register bus, forwards same-cycle
// write-back data, flags load-use hazards and registers the operands with
// flush/hold/bubble handling. A held operand is refreshed by a matching
// write-back so it never goes stale while the stage is frozen.
module regfile_read_stage #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int IW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREG*DW-1:0]   Q,
  input  logic                 in_valid,
  input  logic [IW-1:0]        rs,
  input  logic [IW-1:0]        rt,
  input  logic                 RegWrite,
  input  logic [IW-1:0]        WriteRegister,
  input  logic [DW-1:0]        WriteData,
  input  logic                 ex_load,
  input  logic [IW-1:0]        ex_rd,
  input  logic                 flush,
  input  logic                 hold,
  output logic                 load_use_stall,
  output logic                 out_valid,
  output logic [IW-1:0]        out_rs,
  output logic [IW-1:0]        out_rt,
  output logic [DW-1:0]        rs_data,
  output logic [DW-1:0]        rt_data
);

  // Raw register read; register 0 is hardwired to zero regardless of Q.
  function automatic logic [DW-1:0] select_reg(input logic [NREG*DW-1:0] q,
                                               input logic [IW-1:0]      idx);
    logic [DW-1:0] r;
    if (idx == {IW{1'b0}}) begin
      r = {DW{1'b0}};
    end else begin
      r = q[idx*DW +: DW];
    end
    return r;
  endfunction

  // Operand with same-cycle write-back forwarding; register 0 is never bypassed.
  function automatic logic [DW-1:0] bypass_reg(input logic [NREG*DW-1:0] q,
                                               input logic [IW-1:0]      idx,
                                               input logic               we,
                                               input logic [IW-1:0]      widx,
                                               input logic [DW-1:0]      wdata);
    logic [DW-1:0] r;
    if (we && (widx == idx) && (idx != {IW{1'b0}})) begin
      r = wdata;
    end else begin
      r = select_reg(q, idx);
    end
    return r;
  endfunction

  logic [DW-1:0] rs_operand;
  logic [DW-1:0] rt_operand;
  logic          next_valid;
  logic [IW-1:0] next_rs;
  logic [IW-1:0] next_rt;
  logic [DW-1:0] next_rs_data;
  logic [DW-1:0] next_rt_data;
  logic          refresh_en;

  // Operand selection and load-use hazard detection (independent of hold/flush).
  always_comb begin
    rs_operand     = bypass_reg(Q, rs, RegWrite, WriteRegister, WriteData);
    rt_operand     = bypass_reg(Q, rt, RegWrite, WriteRegister, WriteData);
    load_use_stall = in_valid && ex_load && (ex_rd != {IW{1'b0}}) &&
                     ((ex_rd == rs) || (ex_rd == rt));
  end

  // Next value of the pipeline register: flush > hold > bubble > capture.
  always_comb begin
    next_valid   = out_valid;
    next_rs      = out_rs;
    next_rt      = out_rt;
    next_rs_data = rs_data;
    next_rt_data = rt_data;
    refresh_en   = out_valid && RegWrite && (WriteRegister != {IW{1'b0}});
    if (flush) begin
      next_valid   = 1'b0;
      next_rs      = {IW{1'b0}};
      next_rt      = {IW{1'b0}};
      next_rs_data = {DW{1'b0}};
      next_rt_data = {DW{1'b0}};
    end else if (hold) begin
      if (refresh_en && (WriteRegister == out_rs)) begin
        next_rs_data = WriteData;
      end else begin
        next_rs_data = rs_data;
      end
      if (refresh_en && (WriteRegister == out_rt)) begin
        next_rt_data = WriteData;
      end else begin
        next_rt_data = rt_data;
      end
    end else if (load_use_stall) begin
      next_valid   = 1'b0;
      next_rs      = {IW{1'b0}};
      next_rt      = {IW{1'b0}};
      next_rs_data = {DW{1'b0}};
      next_rt_data = {DW{1'b0}};
    end else begin
      next_valid   = in_valid;
      next_rs      = rs;
      next_rt      = rt;
      next_rs_data = rs_operand;
      next_rt_data = rt_operand;
    end
  end

  // ID/EX operand register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_rs    <= {IW{1'b0}};
      out_rt    <= {IW{1'b0}};
      rs_data   <= {DW{1'b0}};
      rt_data   <= {DW{1'b0}};
    end else begin
      out_valid <= next_valid;
      out_rs    <= next_rs;
      out_rt    <= next_rt;
      rs_data   <= next_rs_data;
      rt_data   <= next_rt_data;
    end
  end

endmodule

// File: tb/tb_regfile_read_stage.sv
// Self-checking bench for regfile_read_stage: directed scenarios followed by
// randomized traffic, all checked against an array-based reference model.
module tb_regfile_read_stage;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1023:0] q;
  logic          in_valid;
  logic [4:0]    rs, rt;
  logic          reg_write;
  logic [4:0]    wreg;
  logic [31:0]   wdata;
  logic          ex_load;
  logic [4:0]    ex_rd;
  logic          flush, hold;
  logic          load_use_stall, out_valid;
  logic [4:0]    out_rs, out_rt;
  logic [31:0]   rs_data, rt_data;

  regfile_read_stage dut (
    .clk(clk), .rst_n(rst_n), .Q(q), .in_valid(in_valid), .rs(rs), .rt(rt),
    .RegWrite(reg_write), .WriteRegister(wreg), .WriteData(wdata),
    .ex_load(ex_load), .ex_rd(ex_rd), .flush(flush), .hold(hold),
    .load_use_stall(load_use_stall), .out_valid(out_valid),
    .out_rs(out_rs), .out_rt(out_rt), .rs_data(rs_data), .rt_data(rt_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] regs [32];
  logic        m_valid;
  logic [4:0]  m_rs, m_rt;
  logic [31:0] m_rsd, m_rtd;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic pack_q();
    for (int i = 0; i < 32; i++) q[32*i +: 32] = regs[i];
  endtask

  function automatic logic [31:0] operand(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (reg_write && wreg == idx) return wdata;
    return regs[idx];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_rs = 5'd0; m_rt = 5'd0; m_rsd = 32'd0; m_rtd = 32'd0;
  endtask

  task automatic model_edge(input logic stall);
    if (flush) begin
      model_reset();
    end else if (hold) begin
      if (m_valid && reg_write && wreg != 5'd0) begin
        if (wreg == m_rs) m_rsd = wdata;
        if (wreg == m_rt) m_rtd = wdata;
      end
    end else if (stall) begin
      m_valid = 1'b0; m_rsd = 32'd0; m_rtd = 32'd0;
    end else begin
      m_valid = in_valid; m_rs = rs; m_rt = rt;
      m_rsd = operand(rs); m_rtd = operand(rt);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    check_val({tag, ".rs_data"}, rs_data, m_rsd);
    check_val({tag, ".rt_data"}, rt_data, m_rtd);
    if (m_valid) begin
      check_val({tag, ".out_rs"}, {27'd0, out_rs}, {27'd0, m_rs});
      check_val({tag, ".out_rt"}, {27'd0, out_rt}, {27'd0, m_rt});
    end
  endtask

  // Called at a negedge with inputs driven; checks stall, advances one edge.
  task automatic step(input string tag);
    logic exp_stall;
    pack_q();
    #1;
    exp_stall = in_valid && ex_load && (ex_rd != 5'd0) && (ex_rd == rs || ex_rd == rt);
    check_val({tag, ".stall"}, {31'd0, load_use_stall}, {31'd0, exp_stall});
    model_edge(exp_stall);
    @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; rs = 5'd0; rt = 5'd0; reg_write = 1'b0; wreg = 5'd0;
    wdata = 32'd0; ex_load = 1'b0; ex_rd = 5'd0; flush = 1'b0; hold = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hA5A5_5A5A;  // must never be visible through index 0
    pack_q();
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: plain read, rt reads register 0
    regs[5] = 32'h1234_5678;
    in_valid = 1'b1; rs = 5'd5; rt = 5'd0;
    step("t1");
    check_val("t1.literal", rs_data, 32'h1234_5678);

    // 2: bypass, then write to register 0 is not forwarded
    reg_write = 1'b1; wreg = 5'd5; wdata = 32'hDEAD_BEEF;
    step("t2a");
    check_val("t2a.literal", rs_data, 32'hDEAD_BEEF);
    rs = 5'd0; wreg = 5'd0;
    step("t2b");
    reg_write = 1'b0;

    // 3: load-use hazard bubble, ex_rd=0 never stalls
    rs = 5'd2; rt = 5'd7; ex_load = 1'b1; ex_rd = 5'd7;
    step("t3a");
    check_val("t3a.literal", {31'd0, out_valid}, 32'd0);
    rt = 5'd0; ex_rd = 5'd0;
    step("t3b");
    ex_load = 1'b0;

    // 4: hold with refresh of held operand
    regs[3] = 32'h0000_0011; rs = 5'd3; rt = 5'd4;
    step("t4cap");
    hold = 1'b1; rs = 5'd9; rt = 5'd10;
    step("t4h1");
    reg_write = 1'b1; wreg = 5'd3; wdata = 32'h0000_0099;
    step("t4h2");
    reg_write = 1'b0;
    step("t4h3");
    check_val("t4.literal", rs_data, 32'h0000_0099);

    // 5: flush beats hold
    flush = 1'b1;
    step("t5");
    flush = 1'b0; hold = 1'b0;

    // 6: async reset between edges, then capture register 31
    rs = 5'd6; rt = 5'd6;
    step("t6cap");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("t6rst");
    @(negedge clk);
    rst_n = 1'b1;
    regs[31] = 32'hFFFF_FFFF; rs = 5'd31; rt = 5'd31;
    step("t6rel");
    check_val("t6.literal", rs_data, 32'hFFFF_FFFF);

    // randomized traffic; small index range raises match frequency
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 31)] = $urandom;
      in_valid  = ($urandom_range(0, 9) != 0);
      rs        = 5'($urandom_range(0, 7));
      rt        = ($urandom_range(0, 5) == 0) ? rs : 5'($urandom_range(0, 7));
      reg_write = $urandom_range(0, 1) == 1;
      wreg      = 5'($urandom_range(0, 7));
      wdata     = $urandom;
      ex_load   = ($urandom_range(0, 3) == 0);
      ex_rd     = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 11) == 0);
      hold      = ($urandom_range(0, 4) == 0);
      if (n % 10 == 0) regs[rs] = 32'hFFFF_FFFF;
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
